// File: rtl/router_reg.sv
// Datapath register stage of the 1x3 router: header/full-byte capture, FIFO write data and XOR parity check.
// Define ROUTER_REG_ERR_CNT_EN to add the saturating err_count output (width ERR_CNT_W).
module router_reg #(
   parameter int DATA_W = 8
`ifdef ROUTER_REG_ERR_CNT_EN
   , parameter int ERR_CNT_W = 8
`endif
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              pkt_valid,
   input  logic [DATA_W-1:0] data_in,
   input  logic              fifo_full,
   input  logic              detect_add,
   input  logic              lfd_state,
   input  logic              ld_state,
   input  logic              laf_state,
   input  logic              full_state,
   input  logic              rst_int_reg,
   output logic [DATA_W-1:0] dout,
   output logic              parity_done,
   output logic              low_packet_valid,
   output logic              err
`ifdef ROUTER_REG_ERR_CNT_EN
   , output logic [ERR_CNT_W-1:0] err_count
`endif
);

   logic [DATA_W-1:0] header_byte;
   logic [DATA_W-1:0] full_byte;
   logic [DATA_W-1:0] int_parity;
   logic [DATA_W-1:0] pkt_parity;
   logic              hdr_ok;
   logic              capture;
   logic              err_next;

   assign hdr_ok = detect_add & pkt_valid & (data_in[1:0] != 2'b11);

   // Parity byte arrives either directly in LOAD_DATA or, if the FIFO was full then, replayed in LAF.
   assign capture = (ld_state & ~pkt_valid & ~fifo_full) |
                    (laf_state & low_packet_valid & ~parity_done);

   always_comb begin
      err_next = err;
      if (detect_add)
         err_next = 1'b0;
      else if (parity_done)
         err_next = (int_parity != pkt_parity);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         header_byte <= '0;
         full_byte   <= '0;
         dout        <= '0;
      end else begin
         if (hdr_ok)
            header_byte <= data_in;
         if (ld_state && fifo_full)
            full_byte <= data_in;
         if (lfd_state)
            dout <= header_byte;
         else if (ld_state && !fifo_full)
            dout <= data_in;
         else if (laf_state)
            dout <= full_byte;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         int_parity <= '0;
      end else if (detect_add) begin
         int_parity <= '0;
      end else if (lfd_state) begin
         int_parity <= int_parity ^ header_byte;
      end else if (ld_state && pkt_valid && !full_state) begin
         int_parity <= int_parity ^ data_in;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pkt_parity       <= '0;
         parity_done      <= 1'b0;
         low_packet_valid <= 1'b0;
         err              <= 1'b0;
      end else begin
         if (detect_add) begin
            parity_done <= 1'b0;
         end else if (capture) begin
            parity_done <= 1'b1;
            pkt_parity  <= data_in;
         end
         if (rst_int_reg)
            low_packet_valid <= 1'b0;
         else if (ld_state && !pkt_valid)
            low_packet_valid <= 1'b1;
         err <= err_next;
      end
   end

`ifdef ROUTER_REG_ERR_CNT_EN
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         err_count <= '0;
      else if (err_next && !err && (err_count != '1))
         err_count <= err_count + ERR_CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg: the bench plays router_fsm and checks against a packet-level model.
module tb_router_reg;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       pkt_valid = 1'b0;
   logic [7:0] data_in = '0;
   logic       fifo_full = 1'b0;
   logic       detect_add = 1'b0;
   logic       lfd_state = 1'b0;
   logic       ld_state = 1'b0;
   logic       laf_state = 1'b0;
   logic       full_state = 1'b0;
   logic       rst_int_reg = 1'b0;
   logic [7:0] dout;
   logic       parity_done;
   logic       low_packet_valid;
   logic       err;
`ifdef ROUTER_REG_ERR_CNT_EN
   logic [7:0] err_count;
`endif

   router_reg dut (
      .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
      .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
      .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
      .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
      .low_packet_valid(low_packet_valid), .err(err)
`ifdef ROUTER_REG_ERR_CNT_EN
      , .err_count(err_count)
`endif
   );

   always #5 clock = ~clock;

   int n_pass = 0;
   int n_total = 0;
   logic check_en = 1'b0;

   // Model: last byte written to the FIFO, and packet-level status flags.
   logic [7:0] exp_dout = '0;
   logic       exp_pd = 1'b0;
   logic       exp_lpv = 1'b0;
   logic       exp_err = 1'b0;
   int         exp_cnt = 0;
   logic [7:0] pl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
   endtask

   always @(posedge clock) begin
      #1;
      if (check_en) begin
         chk("dout", 32'(dout), 32'(exp_dout));
         chk("parity_done", 32'(parity_done), 32'(exp_pd));
         chk("low_packet_valid", 32'(low_packet_valid), 32'(exp_lpv));
         chk("err", 32'(err), 32'(exp_err));
`ifdef ROUTER_REG_ERR_CNT_EN
         chk("err_count", 32'(err_count), 32'(exp_cnt));
`endif
      end
   end

   task automatic drive(input logic da, input logic lfd, input logic ld, input logic laf,
                        input logic fs, input logic rir, input logic pv, input logic ff,
                        input logic [7:0] d);
      @(negedge clock);
      detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
      full_state = fs; rst_int_reg = rir; pkt_valid = pv; fifo_full = ff; data_in = d;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 8'($urandom));
   endtask

   task automatic set_err(input logic e);
      if (e && !exp_err && exp_cnt < 255) exp_cnt++;
      exp_err = e;
   endtask

   // stall: payload index whose write sees a full FIFO, pl.size() for the parity byte, -1 for none.
   // abort: stop right after that payload index (used for mid-packet reset), -1 for a full packet.
   task automatic send_pkt(input logic [7:0] hdr, input bit bad, input int stall,
                           input bit junk_da, input int abort);
      logic [7:0] x, par, nx;
      int n;
      bit mism;
      n = pl.size();
      x = hdr;
      foreach (pl[i]) x = x ^ pl[i];
      par  = bad ? (x ^ 8'(1 << $urandom_range(0, 7))) : x;
      mism = (par != x);
      if ($urandom_range(0, 1) == 1) begin
         drive(1, 0, 0, 0, 0, 0, 1, 0, {6'($urandom), 2'b11});
         exp_pd = 0; exp_err = 0;
      end
      drive(1, 0, 0, 0, 0, 0, 1, 0, hdr);
      exp_pd = 0; exp_err = 0;
      if (junk_da) begin
         drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h0F);
         drive(1, 0, 0, 0, 0, 0, 0, 0, {6'($urandom), 2'b01});
      end
      drive(0, 1, 0, 0, 0, 0, 1, 0, pl[0]);
      exp_dout = hdr;
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 1, 0, 0, 0, 1, (i == stall), pl[i]);
         if (i != stall) begin
            exp_dout = pl[i];
         end else begin
            nx = (i + 1 < n) ? pl[i+1] : 8'h5A;
            drive(0, 0, 0, 0, 1, 0, 1, 1, nx);
            drive(0, 0, 0, 1, 0, 0, 1, 0, nx);
            exp_dout = pl[i];
         end
         if (i == abort) return;
      end
      drive(0, 0, 1, 0, 0, 0, 0, (stall == n), par);
      exp_lpv = 1;
      if (stall != n) begin
         exp_dout = par; exp_pd = 1;
      end else begin
         drive(0, 0, 0, 0, 1, 0, 0, 1, par);
         drive(0, 0, 0, 1, 0, 0, 0, 0, par);
         exp_dout = par; exp_pd = 1;
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0, 8'($urandom));
      set_err(mism);
      drive(0, 0, 0, 0, 0, 1, 0, 0, 8'($urandom));
      exp_lpv = 0;
      repeat ($urandom_range(0, 2)) idle();
   endtask

   task automatic std_payload();
      pl.delete();
      pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
   endtask

   task automatic lit_after();
      @(posedge clock);
      #2;
   endtask

   initial begin
      int len, st;
      repeat (2) idle();
      resetn = 1;
      check_en = 1;

      std_payload();
      send_pkt(8'h0C, 0, -1, 0, -1);
      lit_after();
      chk("good_err", 32'(err), 32'h0);
      chk("good_dout", 32'(dout), 32'h0C);

      std_payload();
      send_pkt(8'h0C, 0, -1, 0, -1);
      pl.delete(); pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
      // Directed bad parity 0x0D: drive by hand so the parity byte is exactly 0x0D.
      drive(1, 0, 0, 0, 0, 0, 1, 0, 8'h0C); exp_pd = 0; exp_err = 0;
      drive(0, 1, 0, 0, 0, 0, 1, 0, 8'h11); exp_dout = 8'h0C;
      foreach (pl[i]) begin drive(0, 0, 1, 0, 0, 0, 1, 0, pl[i]); exp_dout = pl[i]; end
      drive(0, 0, 1, 0, 0, 0, 0, 0, 8'h0D); exp_dout = 8'h0D; exp_pd = 1; exp_lpv = 1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 8'h00); set_err(1);
      drive(0, 0, 0, 0, 0, 1, 0, 0, 8'h00); exp_lpv = 0;
      lit_after();
      chk("bad_err", 32'(err), 32'h1);
      chk("bad_dout", 32'(dout), 32'h0D);
      std_payload();
      send_pkt(8'h0C, 0, -1, 0, -1);
      lit_after();
      chk("err_cleared", 32'(err), 32'h0);

      std_payload();
      send_pkt(8'h0C, 0, 1, 0, -1);
      lit_after();
      chk("stall_err", 32'(err), 32'h0);

      std_payload();
      send_pkt(8'h0C, 0, 3, 0, -1);
      lit_after();
      chk("stall_par_lpv", 32'(low_packet_valid), 32'h0);
      chk("stall_par_pd", 32'(parity_done), 32'h1);

      std_payload();
      send_pkt(8'h0D, 0, -1, 1, -1);

      std_payload();
      send_pkt(8'h0C, 0, -1, 0, 1);
      @(posedge clock);
      #3;
      resetn = 0;
      check_en = 0;
      #1;
      chk("rst_dout", 32'(dout), 32'h0);
      chk("rst_pd", 32'(parity_done), 32'h0);
      chk("rst_lpv", 32'(low_packet_valid), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      idle();
      resetn = 1;
      exp_dout = 0; exp_pd = 0; exp_lpv = 0; exp_err = 0; exp_cnt = 0;
      check_en = 1;

      for (int k = 0; k < 60; k++) begin
         pl.delete();
         len = $urandom_range(1, 8);
         repeat (len) pl.push_back(8'($urandom));
         st = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len) : -1;
         send_pkt({6'($urandom), 2'($urandom_range(0, 2))}, ($urandom_range(0, 3) == 0), st,
                  ($urandom_range(0, 4) == 0), -1);
      end

      for (int k = 0; k < 258; k++) begin
         pl.delete();
         pl.push_back(8'($urandom));
         send_pkt({6'($urandom), 2'b10}, 1, -1, 0, -1);
      end
      lit_after();
      chk("sat_err", 32'(err), 32'h1);
`ifdef ROUTER_REG_ERR_CNT_EN
      chk("sat_count", 32'(err_count), 32'hFF);
`endif

      idle();
      check_en = 0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
